ctrl_seq: RTL and testbench

CTRL_SEQ -- requirements
Module: ctrl_seq

---
 rtl/ctrl_seq.sv | 204 ++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_seq
// Description : Multi-cycle instruction sequencer. Fetches a 9-bit instruction
//               (op=[8:6], f=[5:3], r=[2:0]), decodes it into ALU and
//               register-file controls, performs data-memory handshakes for
//               LD/ST, evaluates BZ against the latched zero flag Z, and
//               parks in HALT until restarted.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start             - one-cycle run pulse (IDLE/HALT only)
//               pc                - instruction fetch address
//               instr_req         - fetch request, high in FETCH
//               instr_valid/_in   - instruction handshake and word
//               alu_cmd, ALU_Op   - ALU function / mode select
//               zero              - ALU zero flag (sampled at end of EXEC)
//               reg_sel, reg_we   - register index and one-cycle write strobe
//               mem_req, mem_we   - data-memory request / write qualifier
//               mem_ack           - data-memory completion
//               done              - high while halted
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq #(
    parameter int PC_W     = 8,
    parameter int START_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] pc,
    output logic            instr_req,
    input  logic            instr_valid,
    input  logic [8:0]      instr_in,
    output logic [2:0]      alu_cmd,
    output logic [1:0]      ALU_Op,
    input  logic            zero,
    output logic [2:0]      reg_sel,
    output logic            reg_we,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            done
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_halt   = 3'd6;

    localparam logic [2:0] c_op_alu  = 3'b000;
    localparam logic [2:0] c_op_dec  = 3'b001;
    localparam logic [2:0] c_op_inc  = 3'b010;
    localparam logic [2:0] c_op_cmp  = 3'b011;
    localparam logic [2:0] c_op_bz   = 3'b100;
    localparam logic [2:0] c_op_ld   = 3'b101;
    localparam logic [2:0] c_op_st   = 3'b110;
    localparam logic [2:0] c_op_halt = 3'b111;

    localparam logic [PC_W-1:0] c_start_pc = START_PC[PC_W-1:0];

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [8:0]      r_ir;
    logic [8:0]      w_ir_next;
    logic            r_z;
    logic            w_z_next;

    logic [2:0]      w_op;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_bz_off;

    assign w_op     = r_ir[8:6];
    assign w_pc_inc = r_pc + PC_W'(1);
    // Signed cast sign-extends the 6-bit branch offset to the PC width;
    // the add then wraps naturally modulo 2^PC_W.
    assign w_bz_off = PC_W'($signed(r_ir[5:0]));

    // ------------------------------------------------------------------
    // State, PC, IR and Z registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_pc    <= c_start_pc;
            r_ir    <= '0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ir    <= w_ir_next;
            r_z     <= w_z_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_next    = r_ir;
        w_z_next     = r_z;

        case (r_state)
            c_st_idle, c_st_halt: begin
                // PC stays frozen here until a new run is requested.
                if (start) begin
                    w_state_next = c_st_fetch;
                    w_pc_next    = c_start_pc;
                    w_z_next     = 1'b0;
                end
            end
            c_st_fetch: begin
                if (instr_valid) begin
                    w_ir_next    = instr_in;
                    w_state_next = c_st_decode;
                end
            end
            c_st_decode: begin
                w_state_next = c_st_exec;
            end
            c_st_exec: begin
                // Ops 000-011 all use the ALU, so they share the Z capture.
                if (w_op[2] == 1'b0) begin
                    w_z_next = zero;
                end
                case (w_op)
                    c_op_alu, c_op_dec, c_op_inc: begin
                        w_state_next = c_st_wb;
                    end
                    c_op_cmp: begin
                        w_state_next = c_st_fetch;
                        w_pc_next    = w_pc_inc;
                    end
                    c_op_bz: begin
                        w_state_next = c_st_fetch;
                        w_pc_next    = r_z ? (r_pc + w_bz_off) : w_pc_inc;
                    end
                    c_op_ld, c_op_st: begin
                        w_state_next = c_st_mem;
                    end
                    default: begin
                        w_state_next = c_st_halt;
                    end
                endcase
            end
            c_st_mem: begin
                if (mem_ack) begin
                    if (w_op == c_op_ld) begin
                        w_state_next = c_st_wb;
                    end else begin
                        w_state_next = c_st_fetch;
                        w_pc_next    = w_pc_inc;
                    end
                end
            end
            c_st_wb: begin
                w_state_next = c_st_fetch;
                w_pc_next    = w_pc_inc;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, from state and IR)
    // ------------------------------------------------------------------
    always_comb begin
        alu_cmd   = 3'b000;
        ALU_Op    = 2'b00;
        reg_sel   = 3'b000;
        instr_req = (r_state == c_st_fetch);
        reg_we    = (r_state == c_st_wb);
        mem_req   = (r_state == c_st_mem);
        mem_we    = (r_state == c_st_mem) && (w_op == c_op_st);
        done      = (r_state == c_st_halt);

        // ALU/register controls follow IR only once it holds a fresh word.
        if ((r_state == c_st_decode) || (r_state == c_st_exec) ||
            (r_state == c_st_mem)    || (r_state == c_st_wb)) begin
            reg_sel = r_ir[2:0];
            case (w_op)
                c_op_alu: begin
                    ALU_Op  = 2'b00;
                    alu_cmd = r_ir[5:3];
                end
                c_op_dec: ALU_Op = 2'b01;
                c_op_inc: ALU_Op = 2'b10;
                c_op_cmp: ALU_Op = 2'b11;
                default:  ALU_Op = 2'b00;
            endcase
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ctrl_seq
// Description : Self-checking bench for ctrl_seq. A table of single
//               instructions (forming one straight-line program with
//               branches) is applied in a loop; directed sequences cover
//               branch wrap, memory waits, HALT/restart and reset mid-wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       instr_valid = 1'b0;
    logic [8:0] instr_in = 9'd0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;

    logic [7:0] pc;
    logic       instr_req;
    logic [2:0] alu_cmd;
    logic [1:0] ALU_Op;
    logic [2:0] reg_sel;
    logic       reg_we;
    logic       mem_req;
    logic       mem_we;
    logic       done;

    int total = 0;
    int bad   = 0;

    ctrl_seq #(.PC_W(8), .START_PC(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .instr_req  (instr_req),
        .instr_valid(instr_valid),
        .instr_in   (instr_in),
        .alu_cmd    (alu_cmd),
        .ALU_Op     (ALU_Op),
        .zero       (zero),
        .reg_sel    (reg_sel),
        .reg_we     (reg_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] instr;
        logic       zin;
        logic       chk_alu;
        logic [2:0] cmd;
        logic [1:0] aop;
        logic [2:0] sel;
        int         we;
        int         lat;
        logic [7:0] pc_after;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " pc"},        32'(pc),        32'd0);
        chk({tag, " instr_req"}, 32'(instr_req), 32'd0);
        chk({tag, " alu_cmd"},   32'(alu_cmd),   32'd0);
        chk({tag, " ALU_Op"},    32'(ALU_Op),    32'd0);
        chk({tag, " reg_sel"},   32'(reg_sel),   32'd0);
        chk({tag, " reg_we"},    32'(reg_we),    32'd0);
        chk({tag, " mem_req"},   32'(mem_req),   32'd0);
        chk({tag, " mem_we"},    32'(mem_we),    32'd0);
        chk({tag, " done"},      32'(done),      32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start fetch", 32'(instr_req), 32'd1);
        chk("start pc",    32'(pc),        32'd0);
    endtask

    // Present one instruction in FETCH; returns in the DECODE cycle.
    task automatic issue(input logic [8:0] ins, input logic z);
        zero        = z;
        instr_in    = ins;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    // From DECODE, run until the next FETCH entry (bounded).
    task automatic finish(output int lat, output int wes);
        lat = 1;
        wes = 0;
        while (instr_req !== 1'b1 && done !== 1'b1 && lat < 40) begin
            if (reg_we === 1'b1) wes++;
            step();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int wes;
        int g;
        logic [7:0] pc_hold;

        //            instr           zin  alu  cmd  aop    sel  we lat pc
        tbl[0]  = '{9'b000_011_010, 1'b0, 1'b1, 3'd3, 2'b00, 3'd2, 1, 4, 8'd1};
        tbl[1]  = '{9'b001_000_101, 1'b1, 1'b1, 3'd0, 2'b01, 3'd5, 1, 4, 8'd2};
        tbl[2]  = '{9'b010_000_000, 1'b0, 1'b1, 3'd0, 2'b10, 3'd0, 1, 4, 8'd3};
        tbl[3]  = '{9'b011_000_001, 1'b1, 1'b1, 3'd0, 2'b11, 3'd1, 0, 3, 8'd4};
        tbl[4]  = '{9'b100_000_101, 1'b0, 1'b0, 3'd0, 2'b00, 3'd5, 0, 3, 8'd9};
        tbl[5]  = '{9'b100_000_011, 1'b0, 1'b0, 3'd0, 2'b00, 3'd3, 0, 3, 8'd12};
        tbl[6]  = '{9'b000_110_111, 1'b0, 1'b1, 3'd6, 2'b00, 3'd7, 1, 4, 8'd13};
        tbl[7]  = '{9'b100_000_101, 1'b1, 1'b0, 3'd0, 2'b00, 3'd5, 0, 3, 8'd14};
        tbl[8]  = '{9'b011_000_100, 1'b0, 1'b1, 3'd0, 2'b11, 3'd4, 0, 3, 8'd15};
        tbl[9]  = '{9'b100_111_110, 1'b0, 1'b0, 3'd0, 2'b00, 3'd6, 0, 3, 8'd16};
        tbl[10] = '{9'b011_000_000, 1'b1, 1'b1, 3'd0, 2'b11, 3'd0, 0, 3, 8'd17};
        tbl[11] = '{9'b100_111_110, 1'b0, 1'b0, 3'd0, 2'b00, 3'd6, 0, 3, 8'd15};

        // ---------------- reset state ----------------
        step();
        step();
        reset = 1'b0;
        check_reset_outputs("reset");

        // ---------------- table-driven program ----------------
        start_run();
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("row%0d fetch-ready", i), 32'(instr_req), 32'd1);
            issue(tbl[i].instr, tbl[i].zin);
            if (tbl[i].chk_alu) begin
                chk($sformatf("row%0d alu_cmd", i), 32'(alu_cmd), 32'(tbl[i].cmd));
                chk($sformatf("row%0d ALU_Op", i),  32'(ALU_Op),  32'(tbl[i].aop));
            end
            chk($sformatf("row%0d reg_sel", i), 32'(reg_sel), 32'(tbl[i].sel));
            finish(lat, wes);
            chk($sformatf("row%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("row%0d reg_we", i),  32'(wes), 32'(tbl[i].we));
            chk($sformatf("row%0d pc", i),      32'(pc),  32'(tbl[i].pc_after));
        end

        // ---------------- BZ taken / not taken from pc=1 ----------------
        do_reset();
        start_run();
        issue(9'b011_000_000, 1'b1); finish(lat, wes);
        issue(9'b100_000101, 1'b0);  finish(lat, wes);
        chk("bz taken pc", 32'(pc), 32'd6);
        do_reset();
        start_run();
        issue(9'b011_000_000, 1'b0); finish(lat, wes);
        issue(9'b100_000101, 1'b0);  finish(lat, wes);
        chk("bz not taken pc", 32'(pc), 32'd2);

        // ---------------- BZ wrap below zero ----------------
        do_reset();
        start_run();
        issue(9'b011_000_000, 1'b1); finish(lat, wes);
        chk("wrap cmp pc", 32'(pc), 32'd1);
        issue(9'b100_111111, 1'b0);  finish(lat, wes);
        chk("wrap bz1 pc", 32'(pc), 32'd0);
        issue(9'b100_111111, 1'b0);  finish(lat, wes);
        chk("wrap bz2 pc", 32'(pc), 32'hFF);

        // ---------------- LD with delayed ack ----------------
        do_reset();
        start       = 1'b1;
        instr_valid = 1'b1;
        instr_in    = 9'b111_000_000;
        step();
        start       = 1'b0;
        instr_valid = 1'b0;
        chk("entry fetch", 32'(instr_req), 32'd1);
        step();
        chk("entry valid ignored", 32'(instr_req), 32'd1);
        chk("entry no halt",       32'(done),      32'd0);

        issue(9'b101_000_011, 1'b0);
        g = 0;
        while (mem_req !== 1'b1 && g < 5) begin
            step();
            g++;
        end
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("ld mem_req c%0d", k), 32'(mem_req), 32'd1);
            chk($sformatf("ld mem_we c%0d", k),  32'(mem_we),  32'd0);
            chk($sformatf("ld reg_we c%0d", k),  32'(reg_we),  32'd0);
            if (k == 5) mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        chk("ld wb reg_we",  32'(reg_we),  32'd1);
        chk("ld wb mem_req", 32'(mem_req), 32'd0);
        chk("ld wb reg_sel", 32'(reg_sel), 32'd3);
        step();
        chk("ld fetch",      32'(instr_req), 32'd1);
        chk("ld pc",         32'(pc),        32'd1);
        chk("ld post reg_we", 32'(reg_we),   32'd0);

        // ---------------- ST, early ack and stray start ignored ----------------
        issue(9'b110_000_001, 1'b0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st exec mem_req", 32'(mem_req), 32'd0);
        step();
        chk("st mem_req", 32'(mem_req), 32'd1);
        chk("st mem_we",  32'(mem_we),  32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("st start ignored", 32'(mem_req), 32'd1);
        chk("st pc held",       32'(pc),      32'd1);
        wes = 0;
        for (int k = 0; k < 3; k++) begin
            if (reg_we === 1'b1) wes++;
            step();
        end
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        if (reg_we === 1'b1) wes++;
        chk("st no reg_we", 32'(wes),       32'd0);
        chk("st fetch",     32'(instr_req), 32'd1);
        chk("st pc",        32'(pc),        32'd2);

        // ---------------- HALT and restart ----------------
        issue(9'b011_000_000, 1'b1); finish(lat, wes);
        chk("pre-halt pc", 32'(pc), 32'd3);
        issue(9'b111_000_000, 1'b0); finish(lat, wes);
        chk("halt done", 32'(done), 32'd1);
        pc_hold     = pc;
        instr_valid = 1'b1;
        instr_in    = 9'b000_011_010;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("halt done c%0d", k), 32'(done), 32'd1);
            chk($sformatf("halt pc c%0d", k),   32'(pc),   32'(pc_hold));
        end
        instr_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart done", 32'(done),      32'd0);
        chk("restart pc",   32'(pc),        32'd0);
        chk("restart fetch", 32'(instr_req), 32'd1);
        issue(9'b100_000101, 1'b0); finish(lat, wes);
        chk("restart Z cleared", 32'(pc), 32'd1);

        // ---------------- reset during MEM wait ----------------
        issue(9'b101_000_010, 1'b0);
        step();
        step();
        step();
        chk("rst-mem waiting", 32'(mem_req), 32'd1);
        reset = 1'b1;
        mem_ack = 1'b0;
        step();
        reset = 1'b0;
        check_reset_outputs("rst-mem");
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("late ack reg_we",    32'(reg_we),    32'd0);
        chk("late ack mem_req",   32'(mem_req),   32'd0);
        chk("late ack instr_req", 32'(instr_req), 32'd0);
        chk("late ack pc",        32'(pc),        32'd0);

        // ---------------- reset dominates start ----------------
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("reset over start", 32'(instr_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
